// File: rtl/ldpc_dvb_dec_hd_out_reader.sv
// Hard-decision output reader: pulls decoded words from the SRL output FIFO,
// hides its one-cycle read latency in a 2-entry buffer and presents framed
// words (sop/eop) on a valid/ready port. odone pulses after the last word.
module ldpc_dvb_dec_hd_out_reader #(
  parameter int pDAT_W = 8,
  parameter int pLEN_W = 16
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic              istart,
  input  logic [pLEN_W-1:0] iflen,
  output logic              obusy,
  output logic              odone,
  output logic              ofifo_read,
  input  logic              ififo_empty,
  input  logic              ififo_rval,
  input  logic [pDAT_W-1:0] ififo_rdat,
  output logic              oval,
  output logic              osop,
  output logic              oeop,
  output logic [pDAT_W-1:0] odat,
  input  logic              irdy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q;
  logic [pLEN_W-1:0] len_q;
  logic [pLEN_W-1:0] issued_q;
  logic [pLEN_W-1:0] xfer_q;
  logic [pDAT_W-1:0] buf0_q;   // head entry, drives odat
  logic [pDAT_W-1:0] buf1_q;   // tail entry
  logic [1:0]        occ_q;
  logic              inflight_q;
  logic              done_q;

  logic [pLEN_W-1:0] last_idx;
  logic              pop;
  logic              wr;
  logic              credit_ok;
  logic              rd;

  // Transfer/write strobes and read issue; buffer credit counts the read in
  // flight and lets a same-cycle pop free a slot.
  always_comb begin
    last_idx  = len_q - pLEN_W'(1);
    pop       = iclkena & (occ_q != 2'd0) & irdy;
    wr        = iclkena & ififo_rval;
    credit_ok = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    rd        = iclkena & (state_q == RUN) & ~ififo_empty &
                (issued_q < len_q) & credit_ok;
  end

  // Frame control: state, length, issue/transfer counters and done pulse.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      xfer_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else if (iclkena) begin
      done_q     <= 1'b0;
      inflight_q <= rd;
      if (rd && issued_q < len_q) begin
        issued_q <= issued_q + pLEN_W'(1);
      end
      if (pop && xfer_q < len_q) begin
        xfer_q <= xfer_q + pLEN_W'(1);
      end
      case (state_q)
        IDLE: begin
          // done_q blocks acceptance so frames are separated by one idle cycle
          if (istart && !done_q) begin
            if (iflen == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q  <= RUN;
              len_q    <= iflen;
              issued_q <= '0;
              xfer_q   <= '0;
            end
          end
        end
        RUN: begin
          if (rd && issued_q == last_idx) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && xfer_q == last_idx) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Two-entry output buffer: FIFO read data enters at the tail, head is output.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      buf0_q <= '0;
      buf1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      case ({wr, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            buf0_q <= ififo_rdat;
          end else begin
            buf1_q <= ififo_rdat;
          end
          if (occ_q != 2'd2) begin
            occ_q <= occ_q + 2'd1;
          end
        end
        2'b01: begin
          buf0_q <= buf1_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            buf0_q <= ififo_rdat;
          end else begin
            buf0_q <= buf1_q;
            buf1_q <= ififo_rdat;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    oval       = (occ_q != 2'd0);
    odat       = buf0_q;
    osop       = oval & (xfer_q == '0);
    oeop       = oval & (xfer_q == last_idx);
    odone      = done_q;
    obusy      = (state_q != IDLE);
    ofifo_read = rd;
  end

`ifndef SYNTHESIS
  // Read data must only arrive during a frame and must always find a free slot.
  always_ff @(posedge iclk) begin
    if (!ireset && iclkena && ififo_rval) begin
      a_rval_in_idle : assert (state_q != IDLE);
      a_buf_overflow : assert (occ_q != 2'd2 || pop);
    end
  end
`endif

endmodule
